// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative RV64M multiplier.
package mul_pkg;

    localparam int MUL_WIDTH   = 64;
    localparam int MUL_LATENCY = MUL_WIDTH + 1;

    typedef enum logic [1:0] {
        MUL_LO,
        MUL_HSS,
        MUL_HSU,
        MUL_HUU
    } mul_op_t;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_CALC,
        MS_SIGN
    } mul_state_t;

endpackage

// File: rtl/mul_operand_prep.sv
// Converts signed operands to magnitudes and derives the product sign.
module mul_operand_prep
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  mul_op_t          op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic [WIDTH-1:0] mcand,
    output logic [WIDTH-1:0] mplier,
    output logic             neg
);

    logic s1;
    logic s2;

    always_comb begin
        s1 = 1'b0;
        s2 = 1'b0;
        unique case (op)
            MUL_HSS: begin
                s1 = rs1[WIDTH-1];
                s2 = rs2[WIDTH-1];
            end
            MUL_HSU: s1 = rs1[WIDTH-1];
            default: ;
        endcase
        // -min wraps to 2^(WIDTH-1), which is the correct unsigned magnitude
        mcand  = s1 ? -rs1 : rs1;
        mplier = s2 ? -rs2 : rs2;
        neg    = s1 ^ s2;
    end

endmodule

// File: rtl/mul_unit_seq.sv
// Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
module mul_unit_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    mul_state_t         state_q, state_d;
    mul_op_t            op_q, op_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   pre_mcand;
    logic [WIDTH-1:0]   pre_mplier;
    logic               pre_neg;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] p;

    mul_operand_prep #(.WIDTH(WIDTH)) u_prep (
        .op     (mul_op_t'(op)),
        .rs1    (rs1),
        .rs2    (rs2),
        .mcand  (pre_mcand),
        .mplier (pre_mplier),
        .neg    (pre_neg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MS_IDLE;
            op_q     <= MUL_LO;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            neg_q    <= neg_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MS_IDLE: if (start) state_d = MS_CALC;
            MS_CALC: begin
                if (cnt_q == CW'(WIDTH - 1))
                    state_d = MS_SIGN;
            end
            MS_SIGN: state_d = MS_IDLE;
            default: state_d = MS_IDLE;
        endcase
    end

    always_comb begin
        op_d     = op_q;
        mcand_d  = mcand_q;
        neg_d    = neg_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        sum      = '0;
        p        = '0;
        unique case (state_q)
            MS_IDLE: begin
                if (start) begin
                    op_d    = mul_op_t'(op);
                    mcand_d = pre_mcand;
                    neg_d   = pre_neg;
                    prod_d  = {{WIDTH{1'b0}}, pre_mplier};
                    cnt_d   = '0;
                end
            end
            MS_CALC: begin
                // carry out of the add becomes the new top bit after the shift
                sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                    + (prod_q[0] ? {1'b0, mcand_q} : '0);
                prod_d = {sum, prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CW'(1);
            end
            MS_SIGN: begin
                p = neg_q ? -prod_q : prod_q;
                result_d = (op_q == MUL_LO) ? p[WIDTH-1:0]
                                            : p[2*WIDTH-1:WIDTH];
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy   = (state_q != MS_IDLE);
        done   = done_q;
        result = result_q;
    end

endmodule
